// File: rtl/threshold_trigger_if.sv
// Sample/trigger bundle between the FFT feature path and the threshold trigger.
// The master drives samples and observes trigger outputs; the slave is the trigger.
interface threshold_trigger_if #(
    parameter int WIDTH    = 9,
    parameter int HEIGHT_W = 5
);
    logic                i_valid;
    logic [WIDTH-1:0]    i_data;
    logic                o_jump;
    logic [HEIGHT_W-1:0] o_height;
    logic [WIDTH-1:0]    o_peak;
    logic                o_busy;

    modport master (
        output i_valid, i_data,
        input  o_jump, o_height, o_peak, o_busy
    );

    modport slave (
        input  i_valid, i_data,
        output o_jump, o_height, o_peak, o_busy
    );
endinterface

// File: rtl/threshold_trigger.sv
// Hysteretic sustained-level trigger: arms at ON_THRESH, fires after HOLD_SAMPLES
// valid samples at or above OFF_THRESH, latches a quantised peak, then locks out.
module threshold_trigger #(
    parameter int WIDTH        = 9,
    parameter int ON_THRESH    = 128,
    parameter int OFF_THRESH   = 96,
    parameter int HOLD_SAMPLES = 200,
    parameter int COOLDOWN     = 0,
    parameter int NLEVELS      = 6,
    parameter int LEVEL_MIN    = 15,
    parameter int LEVEL_STEP   = 3,
    parameter int HEIGHT_W     = 5
) (
    input logic               clk,
    input logic               rst,
    threshold_trigger_if.slave bus
);

    localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);
    localparam int TMR_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [WIDTH-1:0] ON_L   = WIDTH'(ON_THRESH);
    localparam logic [WIDTH-1:0] OFF_L  = WIDTH'(OFF_THRESH);
    localparam logic [CNT_W-1:0] HOLD_L = CNT_W'(HOLD_SAMPLES);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        COOLDOWN_ST = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    count, count_n;
    logic [TMR_W-1:0]    timer, timer_n;
    logic [WIDTH-1:0]    peak, peak_n;
    logic [WIDTH-1:0]    cand;
    logic                fire;
    logic                jump_n;
    logic [HEIGHT_W-1:0] height_n;
    logic [WIDTH-1:0]    peak_out_n;

    // Leading-one scan over the top NLEVELS bits below the MSB; a set MSB
    // folds into the top level, and no set bit gives the floor height of 1.
    function automatic logic [HEIGHT_W-1:0] quantise(input logic [WIDTH-1:0] pk);
        int h;
        h = 1;
        for (int j = NLEVELS - 1; j >= 0; j--) begin
            if (pk[WIDTH-2-j]) h = LEVEL_MIN + (NLEVELS - 1 - j) * LEVEL_STEP;
        end
        if (pk[WIDTH-1]) h = LEVEL_MIN + (NLEVELS - 1) * LEVEL_STEP;
        return HEIGHT_W'(h);
    endfunction

    always_comb begin
        state_n    = state;
        count_n    = count;
        timer_n    = timer;
        peak_n     = peak;
        cand       = peak;
        fire       = 1'b0;
        jump_n     = 1'b0;
        height_n   = bus.o_height;
        peak_out_n = bus.o_peak;

        case (state)
            IDLE: begin
                if (bus.i_valid && (bus.i_data >= ON_L)) begin
                    cand    = bus.i_data;
                    peak_n  = bus.i_data;
                    count_n = CNT_W'(1);
                    state_n = ACCUM;
                    fire    = (HOLD_SAMPLES == 1);
                end
            end
            ACCUM: begin
                if (bus.i_valid) begin
                    if (bus.i_data >= OFF_L) begin
                        cand    = (bus.i_data > peak) ? bus.i_data : peak;
                        peak_n  = cand;
                        count_n = count + 1'b1;
                        fire    = (count_n == HOLD_L);
                    end else begin
                        state_n = IDLE;
                        count_n = '0;
                    end
                end
            end
            COOLDOWN_ST: begin
                // Timer runs on every clock so the lockout is COOLDOWN cycles, not samples.
                if (timer <= TMR_W'(1)) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (fire) begin
            jump_n     = 1'b1;
            peak_out_n = cand;
            height_n   = quantise(cand);
            count_n    = '0;
            if (COOLDOWN == 0) begin
                state_n = IDLE;
            end else begin
                state_n = COOLDOWN_ST;
                timer_n = TMR_W'(COOLDOWN);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= '0;
            timer        <= '0;
            bus.o_jump   <= 1'b0;
            bus.o_height <= '0;
            bus.o_peak   <= '0;
            bus.o_busy   <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            timer        <= timer_n;
            bus.o_jump   <= jump_n;
            bus.o_height <= height_n;
            bus.o_peak   <= peak_out_n;
            bus.o_busy   <= (state_n != IDLE);
        end
    end

    // Running peak is only meaningful while ACCUM, which always reloads it on arming.
    always_ff @(posedge clk) begin
        peak <= peak_n;
    end

endmodule

// File: tb/tb_threshold_trigger.sv
// Scoreboard bench for threshold_trigger: a main instance (HOLD=4, COOLDOWN=8)
// and a low-threshold instance (ON=OFF=1, COOLDOWN=0) that sweeps the height map.
module tb_threshold_trigger;

    logic clk;
    logic rst;

    typedef struct {
        logic [8:0] peak;
        logic [4:0] height;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int errors = 0;
    int checks = 0;

    threshold_trigger_if #(.WIDTH(9), .HEIGHT_W(5)) a_if ();
    threshold_trigger_if #(.WIDTH(9), .HEIGHT_W(5)) b_if ();

    threshold_trigger #(
        .WIDTH(9), .ON_THRESH(128), .OFF_THRESH(96), .HOLD_SAMPLES(4), .COOLDOWN(8),
        .NLEVELS(6), .LEVEL_MIN(15), .LEVEL_STEP(3), .HEIGHT_W(5)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(a_if.slave)
    );

    threshold_trigger #(
        .WIDTH(9), .ON_THRESH(1), .OFF_THRESH(1), .HOLD_SAMPLES(4), .COOLDOWN(0),
        .NLEVELS(6), .LEVEL_MIN(15), .LEVEL_STEP(3), .HEIGHT_W(5)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_a(input int pk, input int h);
        exp_t e;
        e.peak = 9'(pk);
        e.height = 5'(h);
        q_a.push_back(e);
    endtask

    task automatic push_b(input int pk, input int h);
        exp_t e;
        e.peak = 9'(pk);
        e.height = 5'(h);
        q_b.push_back(e);
    endtask

    task automatic drive_a(input logic v, input int d);
        a_if.i_valid = v;
        a_if.i_data  = 9'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input logic v, input int d);
        b_if.i_valid = v;
        b_if.i_data  = 9'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        a_if.i_valid = 1'b0;
        b_if.i_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_if.o_jump) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_jump", 1, 0);
            end else begin
                e = q_a.pop_front();
                chk("a_peak", int'(a_if.o_peak), int'(e.peak));
                chk("a_height", int'(a_if.o_height), int'(e.height));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_if.o_jump) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_jump", 1, 0);
            end else begin
                e = q_b.pop_front();
                chk("b_peak", int'(b_if.o_peak), int'(e.peak));
                chk("b_height", int'(b_if.o_height), int'(e.height));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[8];
        int hts[8];
        vals = '{129, 64, 40, 16, 8, 4, 3, 256};
        hts  = '{30, 27, 24, 21, 18, 15, 1, 30};

        rst = 1'b0;
        a_if.i_valid = 1'b0;
        a_if.i_data  = '0;
        b_if.i_valid = 1'b0;
        b_if.i_data  = '0;

        // Reset held with live random samples
        for (int i = 0; i < 4; i++) begin
            a_if.i_valid = 1'b1;
            a_if.i_data  = 9'($urandom);
            b_if.i_valid = 1'b1;
            b_if.i_data  = 9'($urandom);
            @(negedge clk);
            chk("rst_jump", int'(a_if.o_jump), 0);
            chk("rst_height", int'(a_if.o_height), 0);
            chk("rst_peak", int'(a_if.o_peak), 0);
            chk("rst_busy", int'(a_if.o_busy), 0);
        end
        a_if.i_valid = 1'b0;
        b_if.i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Hysteresis abort, then re-arm from count=1
        drive_a(1, 130);
        drive_a(1, 100);
        drive_a(1, 95);
        chk("abort_busy_low", int'(a_if.o_busy), 0);
        drive_a(1, 130);
        chk("rearm_busy", int'(a_if.o_busy), 1);
        chk("abort_height_held", int'(a_if.o_height), 0);
        drive_a(1, 100);
        drive_a(1, 100);
        push_a(130, 30);
        drive_a(1, 100);
        idle(10);

        // Basic fire with cooldown lockout length
        drive_a(1, 130);
        drive_a(1, 100);
        drive_a(1, 200);
        push_a(200, 30);
        drive_a(1, 97);
        chk("fire_latency", int'(a_if.o_jump), 1);
        a_if.i_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("cooldown_busy", int'(a_if.o_busy), 1);
            drive_a(0, 0);
        end
        chk("cooldown_end_busy", int'(a_if.o_busy), 0);
        chk("height_held", int'(a_if.o_height), 30);
        chk("peak_held", int'(a_if.o_peak), 200);
        idle(3);

        // Invalid gaps during ACCUM, then samples ignored in cooldown
        drive_a(1, 140);
        drive_a(0, 0);
        drive_a(0, 0);
        drive_a(0, 0);
        drive_a(1, 140);
        drive_a(1, 140);
        push_a(140, 30);
        drive_a(1, 140);
        for (int i = 0; i < 8; i++) drive_a(1, 255);
        chk("post_cooldown_busy", int'(a_if.o_busy), 0);
        chk("post_cooldown_peak", int'(a_if.o_peak), 140);
        drive_a(1, 255);
        drive_a(1, 255);
        drive_a(1, 255);
        push_a(255, 30);
        drive_a(1, 255);
        idle(12);

        // Asynchronous reset with three qualifying samples accumulated
        drive_a(1, 130);
        drive_a(1, 130);
        drive_a(1, 130);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", int'(a_if.o_busy), 0);
        chk("async_rst_peak", int'(a_if.o_peak), 0);
        chk("async_rst_height", int'(a_if.o_height), 0);
        a_if.i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive_a(1, 130);
        idle(3);
        drive_a(1, 130);
        drive_a(1, 130);
        push_a(130, 30);
        drive_a(1, 130);
        idle(3);

        // Height map sweep on the low-threshold instance, runs back to back
        for (int k = 0; k < 8; k++) begin
            drive_b(1, vals[k]);
            drive_b(1, vals[k]);
            drive_b(1, vals[k]);
            push_b(vals[k], hts[k]);
            drive_b(1, vals[k]);
        end
        idle(5);
        chk("b_height_held", int'(b_if.o_height), 30);
        chk("b_peak_held", int'(b_if.o_peak), 256);

        idle(5);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
